freelist_alloc_ctrl: RTL and testbench

Controller in front of the rename-stage physical-register freelist.
- Arbitrates the two freelist dequeue ports between the two rename slots, compacting requests onto the head entries.
- Tracks a credit count mirroring freelist occupancy and stalls rename when credits are short.
- Buffers commit-side register releases in a small FIFO and drains them into the freelist's two enqueue ports one cycle later.
- Sequences flush so the freelist is quiescent before rename resumes.

---
 rtl/freelist_alloc_ctrl_pkg.sv | 24 ++
 rtl/freelist_alloc_ctrl_rel_fifo_2w2r.sv | 84 ++++++++
 rtl/freelist_alloc_ctrl.sv | 168 ++++++++++++++++
 tb/tb_freelist_alloc_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freelist_alloc_ctrl_pkg.sv
// Shared rename-stage definitions for the freelist allocation controller.
// Provides the preg index type, freelist sizing constants, the controller
// FSM state encoding and a 2-bit population count helper.
package freelist_alloc_ctrl_pkg;

  localparam int NUM_REGS       = 32;
  localparam int LOG_NUM_REGS   = 5;
  localparam int PREG_IDX_WIDTH = 6;
  localparam int REL_DEPTH      = 8;
  localparam int LOG_REL_DEPTH  = 3;

  typedef logic [PREG_IDX_WIDTH-1:0] preg_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } fl_state_e;

  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/freelist_alloc_ctrl_rel_fifo_2w2r.sv
// rel_fifo_2w2r: two-write / two-read compacting FIFO.
// Ports:
//   clock, reset_n          clock, async active-low reset
//   wr_en                   global write enable (caller guarantees space)
//   wr0_valid/wr0_data      write slot 0 (stored first)
//   wr1_valid/wr1_data      write slot 1 (compacted behind slot 0)
//   rd_num                  number of entries popped this cycle (0..2)
//   rd0_data/rd1_data       head and head+1 entries (valid per count)
//   count                   current occupancy
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module rel_fifo_2w2r #(
  parameter int DEPTH     = 8,
  parameter int LOG_DEPTH = 3,
  parameter int WIDTH     = 6
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic                 wr0_valid,
  input  logic [WIDTH-1:0]     wr0_data,
  input  logic                 wr1_valid,
  input  logic [WIDTH-1:0]     wr1_data,
  input  logic [1:0]           rd_num,
  output logic [WIDTH-1:0]     rd0_data,
  output logic [WIDTH-1:0]     rd1_data,
  output logic [LOG_DEPTH:0]   count
);

  localparam int PW = LOG_DEPTH + 1;
  typedef logic [PW-1:0] ptr_t;

  ptr_t                        wr_ptr_q, wr_ptr_d;
  ptr_t                        rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [LOG_DEPTH-1:0]        wr_idx0, wr_idx1, rd_idx0, rd_idx1;
  logic [1:0]                  wr_n;
  logic                        full, empty;

  // Index arithmetic wraps naturally in LOG_DEPTH bits.
  assign wr_idx0 = wr_ptr_q[LOG_DEPTH-1:0];
  assign wr_idx1 = wr_idx0 + 1'b1;
  assign rd_idx0 = rd_ptr_q[LOG_DEPTH-1:0];
  assign rd_idx1 = rd_idx0 + 1'b1;

  assign rd0_data = mem_q[rd_idx0];
  assign rd1_data = mem_q[rd_idx1];
  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_idx0 == rd_idx0) && (wr_ptr_q[LOG_DEPTH] != rd_ptr_q[LOG_DEPTH]);
  assign wr_n     = wr_en ? {1'b0, wr0_valid} + {1'b0, wr1_valid} : 2'd0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + ptr_t'(wr_n);
    rd_ptr_d = rd_ptr_q + ptr_t'(rd_num);
    if (wr_en) begin
      // A lone slot-1 release lands at the tail, keeping the queue dense.
      if (wr0_valid) begin
        mem_d[wr_idx0] = wr0_data;
        if (wr1_valid) mem_d[wr_idx1] = wr1_data;
      end else if (wr1_valid) begin
        mem_d[wr_idx0] = wr1_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    (wr_n != 2'd0) |-> (!full && (int'(count) + int'(wr_n) <= DEPTH)));
  a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
    (rd_num != 2'd0) |-> (!empty && ({1'b0, rd_num} <= count)));

endmodule

// File: rtl/freelist_alloc_ctrl.sv
// freelist_alloc_ctrl: controller in front of the rename physical-register
// freelist.
// Ports:
//   clock, reset_n                 clock, async active-low reset
//   in_valid/in_need/in_ready      rename group handshake; in_need bit i set
//                                  when slot i needs a destination preg
//   alloc0_preg/alloc1_preg        pregs handed to slot 0/1
//   fl_req*_valid/fl_req*_data     freelist dequeue ports (head, head+1)
//   rel*_valid/rel*_preg/rel_ready commit-side releases into the FIFO
//   fl_write*_valid/_data          registered freelist enqueue ports
//   flush                          pipeline redirect pulse
//   stall_cnt                      saturating count of cycles spent stalled
// Credits mirror freelist occupancy: they drop on dequeue and rise when a
// drained release is presented on fl_write*.
module freelist_alloc_ctrl
  import freelist_alloc_ctrl_pkg::*;
#(
  parameter int NUM_REGS       = freelist_alloc_ctrl_pkg::NUM_REGS,
  parameter int LOG_NUM_REGS   = freelist_alloc_ctrl_pkg::LOG_NUM_REGS,
  parameter int PREG_IDX_WIDTH = freelist_alloc_ctrl_pkg::PREG_IDX_WIDTH,
  parameter int REL_DEPTH      = freelist_alloc_ctrl_pkg::REL_DEPTH,
  parameter int LOG_REL_DEPTH  = freelist_alloc_ctrl_pkg::LOG_REL_DEPTH
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic [1:0]                in_need,
  output logic                      in_ready,
  output logic [PREG_IDX_WIDTH-1:0] alloc0_preg,
  output logic [PREG_IDX_WIDTH-1:0] alloc1_preg,
  output logic                      fl_req0_valid,
  input  logic [PREG_IDX_WIDTH-1:0] fl_req0_data,
  output logic                      fl_req1_valid,
  input  logic [PREG_IDX_WIDTH-1:0] fl_req1_data,
  input  logic                      rel0_valid,
  input  logic [PREG_IDX_WIDTH-1:0] rel0_preg,
  input  logic                      rel1_valid,
  input  logic [PREG_IDX_WIDTH-1:0] rel1_preg,
  output logic                      rel_ready,
  output logic                      fl_write0_valid,
  output logic [PREG_IDX_WIDTH-1:0] fl_write0_data,
  output logic                      fl_write1_valid,
  output logic [PREG_IDX_WIDTH-1:0] fl_write1_data,
  input  logic                      flush,
  output logic [15:0]               stall_cnt
);

  localparam int CW  = LOG_NUM_REGS + 1;
  localparam int RCW = LOG_REL_DEPTH + 1;

  fl_state_e                 state_q, state_d;
  logic [CW-1:0]             credits_q, credits_d;
  logic [15:0]               stall_cnt_q, stall_cnt_d;
  logic                      wr0_valid_q, wr0_valid_d, wr1_valid_q, wr1_valid_d;
  logic [PREG_IDX_WIDTH-1:0] wr0_data_q, wr0_data_d, wr1_data_q, wr1_data_d;

  logic [CW-1:0]             need;
  logic                      fire;
  logic [RCW-1:0]            rel_cnt;
  logic [1:0]                rd_num;
  logic [PREG_IDX_WIDTH-1:0] rel_rd0, rel_rd1;
  logic                      drain_busy;

  // ---------------- dequeue side ----------------
  assign need = CW'(popcnt2(in_need));

  // reset_n gating keeps in_ready low while reset is held, even though the
  // reset credit value alone would allow acceptance.
  assign in_ready = reset_n && (state_q != ST_FLUSH) && !flush && (credits_q >= need);
  assign fire     = in_valid && in_ready;

  // Requests are compacted onto the head: a single need always uses port 0.
  assign fl_req0_valid = fire && (need != '0);
  assign fl_req1_valid = fire && (need == CW'(2));
  assign alloc0_preg   = fl_req0_data;
  assign alloc1_preg   = in_need[0] ? fl_req1_data : fl_req0_data;

  // ---------------- release / drain side ----------------
  assign rel_ready = (rel_cnt <= RCW'(REL_DEPTH - 2));
  assign rd_num    = (rel_cnt >= RCW'(2)) ? 2'd2 : rel_cnt[1:0];

  rel_fifo_2w2r #(
    .DEPTH     (REL_DEPTH),
    .LOG_DEPTH (LOG_REL_DEPTH),
    .WIDTH     (PREG_IDX_WIDTH)
  ) u_rel_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (rel_ready),
    .wr0_valid (rel0_valid),
    .wr0_data  (rel0_preg),
    .wr1_valid (rel1_valid),
    .wr1_data  (rel1_preg),
    .rd_num    (rd_num),
    .rd0_data  (rel_rd0),
    .rd1_data  (rel_rd1),
    .count     (rel_cnt)
  );

  always_comb begin
    wr0_valid_d = (rd_num != 2'd0);
    wr1_valid_d = (rd_num == 2'd2);
    wr0_data_d  = rel_rd0;
    wr1_data_d  = rel_rd1;
  end

  assign fl_write0_valid = wr0_valid_q;
  assign fl_write1_valid = wr1_valid_q;
  assign fl_write0_data  = wr0_data_q;
  assign fl_write1_data  = wr1_data_q;
  assign drain_busy      = wr0_valid_q || wr1_valid_q;

  // ---------------- credits ----------------
  // Returns count when they are actually presented to the freelist, so the
  // credit rise trails fl_write*_valid by one cycle.
  always_comb begin
    credits_d = credits_q - (fire ? need : '0)
              + CW'(wr0_valid_q) + CW'(wr1_valid_q);
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_STALL) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush) begin
      // A repeated flush only holds FLUSH for this cycle; exit is then
      // re-evaluated against the drain state as usual.
      state_d = ST_FLUSH;
    end else begin
      unique case (state_q)
        ST_RUN:   if (in_valid && (credits_q < need)) state_d = ST_STALL;
        ST_STALL: if ((credits_q >= need) || !in_valid) state_d = ST_RUN;
        ST_FLUSH: if ((rel_cnt == '0) && !drain_busy) state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      credits_q   <= CW'(NUM_REGS);
      stall_cnt_q <= '0;
      wr0_valid_q <= 1'b0;
      wr1_valid_q <= 1'b0;
      wr0_data_q  <= '0;
      wr1_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      credits_q   <= credits_d;
      stall_cnt_q <= stall_cnt_d;
      wr0_valid_q <= wr0_valid_d;
      wr1_valid_q <= wr1_valid_d;
      wr0_data_q  <= wr0_data_d;
      wr1_data_q  <= wr1_data_d;
    end
  end

  a_rel_protocol: assert property (@(posedge clock) disable iff (!reset_n)
    (rel0_valid || rel1_valid) |-> rel_ready);
  a_credit_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    credits_d <= CW'(NUM_REGS));

endmodule

// File: tb/tb_freelist_alloc_ctrl.sv
module tb_freelist_alloc_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid, in_ready, flush;
  logic [1:0] in_need;
  logic [5:0] alloc0_preg, alloc1_preg, fl_req0_data, fl_req1_data;
  logic       fl_req0_valid, fl_req1_valid;
  logic       rel0_valid, rel1_valid, rel_ready;
  logic [5:0] rel0_preg, rel1_preg;
  logic       fl_write0_valid, fl_write1_valid;
  logic [5:0] fl_write0_data, fl_write1_data;
  logic [15:0] stall_cnt;

  always #5 clock = ~clock;

  freelist_alloc_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_need(in_need), .in_ready(in_ready),
    .alloc0_preg(alloc0_preg), .alloc1_preg(alloc1_preg),
    .fl_req0_valid(fl_req0_valid), .fl_req0_data(fl_req0_data),
    .fl_req1_valid(fl_req1_valid), .fl_req1_data(fl_req1_data),
    .rel0_valid(rel0_valid), .rel0_preg(rel0_preg),
    .rel1_valid(rel1_valid), .rel1_preg(rel1_preg), .rel_ready(rel_ready),
    .fl_write0_valid(fl_write0_valid), .fl_write0_data(fl_write0_data),
    .fl_write1_valid(fl_write1_valid), .fl_write1_data(fl_write1_data),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: spec-level state kept as plain integers and queues.
  localparam int M_RUN = 0, M_STALL = 1, M_FLUSH = 2;
  int m_credits, m_state, m_stall;
  int m_fifo[$];
  bit m_wv0, m_wv1;
  int m_wd0, m_wd1;
  int fl[$];    // environment freelist contents (head first)
  int held[$];  // pregs currently owned by rename, eligible for release

  function automatic int f_need();
    return int'(in_need[0]) + int'(in_need[1]);
  endfunction

  function automatic bit f_ready();
    return (m_state != M_FLUSH) && !flush && (m_credits >= f_need());
  endfunction

  function automatic bit f_rel_ready();
    return (8 - m_fifo.size()) >= 2;
  endfunction

  task automatic drive_fl();
    fl_req0_data = (fl.size() > 0) ? 6'(fl[0]) : 6'd0;
    fl_req1_data = (fl.size() > 1) ? 6'(fl[1]) : 6'd0;
  endtask

  task automatic model_reset();
    m_credits = 32; m_state = M_RUN; m_stall = 0;
    m_fifo.delete(); m_wv0 = 0; m_wv1 = 0; m_wd0 = 0; m_wd1 = 0;
    fl.delete(); held.delete();
    for (int i = 0; i < 32; i++) fl.push_back(i);
    drive_fl();
  endtask

  task automatic held_remove(input int p);
    for (int i = 0; i < held.size(); i++)
      if (held[i] == p) begin held.delete(i); break; end
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_need = 2'b00; flush = 0;
    rel0_valid = 0; rel1_valid = 0; rel0_preg = 0; rel1_preg = 0;
  endtask

  // Advance one clock: apply spec rules to the model, then let the DUT edge.
  task automatic tick();
    int  need, ns, pops;
    bit  fire, rr;
    need = f_need();
    fire = in_valid && f_ready();
    rr   = f_rel_ready();
    if (fire && need >= 1) held.push_back(fl.pop_front());
    if (fire && need == 2) held.push_back(fl.pop_front());
    if (m_wv0) fl.push_back(m_wd0);
    if (m_wv1) fl.push_back(m_wd1);
    ns = m_state;
    if (flush) ns = M_FLUSH;
    else if (m_state == M_RUN) begin
      if (in_valid && m_credits < need) ns = M_STALL;
    end else if (m_state == M_STALL) begin
      if (m_credits >= need || !in_valid) ns = M_RUN;
    end else if (m_fifo.size() == 0 && !m_wv0 && !m_wv1) ns = M_RUN;
    if (m_state == M_STALL && m_stall < 65535) m_stall++;
    m_credits = m_credits - (fire ? need : 0) + int'(m_wv0) + int'(m_wv1);
    pops = (m_fifo.size() < 2) ? m_fifo.size() : 2;
    m_wv0 = (pops >= 1); if (m_wv0) m_wd0 = m_fifo.pop_front();
    m_wv1 = (pops >= 2); if (m_wv1) m_wd1 = m_fifo.pop_front();
    if (rr) begin
      if (rel0_valid) m_fifo.push_back(int'(rel0_preg));
      if (rel1_valid) m_fifo.push_back(int'(rel1_preg));
    end
    m_state = ns;
    @(posedge clock); #1;
    drive_fl();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    model_reset();
    #2;
    checks++;
    if ({in_ready, rel_ready, fl_write0_valid, fl_write1_valid, fl_req0_valid, fl_req1_valid} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 010000",
               {in_ready, rel_ready, fl_write0_valid, fl_write1_valid, fl_req0_valid, fl_req1_valid});
    end
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    @(negedge clock); reset_n = 1;
    @(posedge clock); #1;
  endtask

  task automatic test_alloc_burst();
    in_valid = 1; in_need = 2'b11;
    for (int i = 0; i < 16; i++) begin
      #2;
      checks++;
      if ({in_ready, fl_req0_valid, fl_req1_valid} !== 3'b111 ||
          alloc0_preg !== 6'(2*i) || alloc1_preg !== 6'(2*i+1)) begin
        errors++;
        $display("FAIL burst_%0d: rdy/req=%b a0=%0d a1=%0d expected 111 a0=%0d a1=%0d",
                 i, {in_ready, fl_req0_valid, fl_req1_valid}, alloc0_preg, alloc1_preg, 2*i, 2*i+1);
      end
      tick();
    end
    #2;
    checks++;
    if ({in_ready, fl_req0_valid, fl_req1_valid} !== 3'b000) begin
      errors++; $display("FAIL burst_exhausted: rdy/req=%b expected 000", {in_ready, fl_req0_valid, fl_req1_valid});
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (stall_cnt !== 16'(m_stall) || m_stall == 0) begin
      errors++; $display("FAIL burst_stall_cnt: got %0d expected %0d (nonzero)", stall_cnt, m_stall);
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_release_timing();
    in_valid = 0; in_need = 2'b11;
    rel0_valid = 1; rel0_preg = 6'd5; rel1_valid = 1; rel1_preg = 6'd9;
    held_remove(5); held_remove(9);
    tick();                         // cycle t
    rel0_valid = 0; rel1_valid = 0;
    #2;                             // t+1
    checks++;
    if ({fl_write0_valid, fl_write1_valid} !== 2'b00) begin
      errors++; $display("FAIL rel_t1_writes: got %b expected 00", {fl_write0_valid, fl_write1_valid});
    end
    tick(); #2;                     // t+2
    checks++;
    if ({fl_write0_valid, fl_write1_valid} !== 2'b11 || fl_write0_data !== 6'd5 || fl_write1_data !== 6'd9) begin
      errors++;
      $display("FAIL rel_t2_writes: v=%b d0=%0d d1=%0d expected v=11 d0=5 d1=9",
               {fl_write0_valid, fl_write1_valid}, fl_write0_data, fl_write1_data);
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rel_t2_credit: in_ready=%b expected 0", in_ready); end
    tick(); #2;                     // t+3
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_t3_credit: in_ready=%b expected 1", in_ready); end
    tick();
  endtask

  task automatic test_single_credit();
    in_valid = 1; in_need = 2'b01;
    #2;
    checks++;
    if ({in_ready, fl_req0_valid, fl_req1_valid} !== 3'b110 || alloc0_preg !== 6'd5) begin
      errors++; $display("FAIL single_slot0: rdy/req=%b a0=%0d expected 110 a0=5",
                         {in_ready, fl_req0_valid, fl_req1_valid}, alloc0_preg);
    end
    tick();
    in_need = 2'b10;                // one credit left
    #2;
    checks++;
    if ({in_ready, fl_req0_valid, fl_req1_valid} !== 3'b110 || alloc1_preg !== 6'd9) begin
      errors++; $display("FAIL single_slot1: rdy/req=%b a1=%0d expected 110 a1=9",
                         {in_ready, fl_req0_valid, fl_req1_valid}, alloc1_preg);
    end
    tick();
    in_valid = 0; in_need = 2'b01;
    #2;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL single_zero_credit: in_ready=%b expected 0", in_ready); end
    tick();
  endtask

  task automatic test_stall_recover();
    int p;
    in_valid = 1; in_need = 2'b01;
    tick(); tick(); tick();
    p = held[0]; held_remove(p);
    rel0_valid = 1; rel0_preg = 6'(p);
    tick();                         // t
    rel0_valid = 0;
    for (int k = 1; k <= 2; k++) begin
      #2;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL recover_t%0d: in_ready=%b expected 0", k, in_ready); end
      tick();
    end
    #2;                             // t+3
    checks++;
    if ({in_ready, fl_req0_valid} !== 2'b11 || alloc0_preg !== 6'(p)) begin
      errors++; $display("FAIL recover_fire: rdy/req0=%b a0=%0d expected 11 a0=%0d",
                         {in_ready, fl_req0_valid}, alloc0_preg, p);
    end
    tick();
    in_valid = 0;
    tick(); tick();
    checks++;
    if (stall_cnt !== 16'(m_stall)) begin
      errors++; $display("FAIL recover_stall_cnt: got %0d expected %0d", stall_cnt, m_stall);
    end
  endtask

  task automatic test_flush();
    bit done = 0;
    rel0_valid = 1; rel0_preg = 6'(held[0]); rel1_valid = 1; rel1_preg = 6'(held[1]);
    held_remove(int'(rel0_preg)); held_remove(int'(rel1_preg));
    tick();
    rel1_valid = 0; rel0_preg = 6'(held[0]); held_remove(int'(rel0_preg));
    flush = 1; in_valid = 1; in_need = 2'b00;
    #2;
    checks++;
    if ({in_ready, fl_req0_valid, fl_req1_valid} !== 3'b000) begin
      errors++; $display("FAIL flush_pulse: rdy/req=%b expected 000", {in_ready, fl_req0_valid, fl_req1_valid});
    end
    tick();
    flush = 0; rel0_valid = 0;
    for (int c = 0; c < 12 && !done; c++) begin
      #2;
      checks++;
      if ({in_ready, fl_write0_valid, fl_write1_valid} !== {f_ready(), m_wv0, m_wv1} ||
          (m_wv0 && fl_write0_data !== 6'(m_wd0))) begin
        errors++;
        $display("FAIL flush_cycle_%0d: rdy/wv=%b d0=%0d expected %b d0=%0d",
                 c, {in_ready, fl_write0_valid, fl_write1_valid}, fl_write0_data,
                 {f_ready(), m_wv0, m_wv1}, m_wd0);
      end
      if (m_state == M_RUN) done = 1;
      tick();
    end
    checks++;
    if (!done) begin errors++; $display("FAIL flush_timeout: state still FLUSH after 12 cycles"); end
  endtask

  task automatic test_random();
    int need, r;
    bit fire;
    logic [5:0] got_v, exp_v;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(3) != 0);
      in_need  = 2'($urandom_range(3));
      flush    = ($urandom_range(19) == 0);
      rel0_valid = 0; rel1_valid = 0;
      if (f_rel_ready() && held.size() > 0 && $urandom_range(1) == 1) begin
        r = $urandom_range(held.size() - 1);
        rel0_valid = 1; rel0_preg = 6'(held[r]); held.delete(r);
      end
      if (f_rel_ready() && held.size() > 0 && $urandom_range(1) == 1) begin
        r = $urandom_range(held.size() - 1);
        rel1_valid = 1; rel1_preg = 6'(held[r]); held.delete(r);
      end
      need = f_need();
      fire = in_valid && f_ready();
      exp_v = {f_ready(), fire && need >= 1, fire && need == 2, f_rel_ready(), m_wv0, m_wv1};
      #2;
      got_v = {in_ready, fl_req0_valid, fl_req1_valid, rel_ready, fl_write0_valid, fl_write1_valid};
      checks++;
      if (got_v !== exp_v || stall_cnt !== 16'(m_stall)) begin
        errors++; $display("FAIL rand_ctrl_%0d: flags=%b stall=%0d expected flags=%b stall=%0d",
                           c, got_v, stall_cnt, exp_v, m_stall);
      end
      if (m_wv0 || m_wv1) begin
        checks++;
        if ((m_wv0 && fl_write0_data !== 6'(m_wd0)) || (m_wv1 && fl_write1_data !== 6'(m_wd1))) begin
          errors++; $display("FAIL rand_write_%0d: d0=%0d d1=%0d expected d0=%0d d1=%0d",
                             c, fl_write0_data, fl_write1_data, m_wd0, m_wd1);
        end
      end
      if (fire && need > 0) begin
        checks++;
        if ((in_need[0] && alloc0_preg !== 6'(fl[0])) ||
            (in_need[1] && alloc1_preg !== 6'(in_need[0] ? fl[1] : fl[0]))) begin
          errors++; $display("FAIL rand_alloc_%0d: a0=%0d a1=%0d need=%b head=%0d", c,
                             alloc0_preg, alloc1_preg, in_need, fl[0]);
        end
      end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_reset_mid();
    rel0_valid = 1; rel0_preg = 6'(held[0]); rel1_valid = 1; rel1_preg = 6'(held[1]);
    held_remove(int'(rel0_preg)); held_remove(int'(rel1_preg));
    tick();
    rel0_valid = 0; rel1_valid = 0;
    tick(); #2;
    checks++;
    if ({fl_write0_valid, fl_write1_valid} !== 2'b11) begin
      errors++; $display("FAIL midreset_pre: wv=%b expected 11", {fl_write0_valid, fl_write1_valid});
    end
    reset_n = 0; #1;
    checks++;
    if ({in_ready, rel_ready, fl_write0_valid, fl_write1_valid} !== 4'b0100 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL midreset_outputs: flags=%b stall=%0d expected 0100 stall=0",
                         {in_ready, rel_ready, fl_write0_valid, fl_write1_valid}, stall_cnt);
    end
    model_reset();
    @(negedge clock); reset_n = 1;
    @(posedge clock); #1;
    in_valid = 1; in_need = 2'b11;
    #2;
    checks++;
    if (in_ready !== 1'b1 || alloc0_preg !== 6'd0 || alloc1_preg !== 6'd1) begin
      errors++; $display("FAIL midreset_after: rdy=%b a0=%0d a1=%0d expected 1 0 1",
                         in_ready, alloc0_preg, alloc1_preg);
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alloc_burst();
    test_release_timing();
    test_single_credit();
    test_stall_recover();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
